uart_tx_serializer: RTL and testbench

Transmit serializer for the UART core, sitting directly downstream of the transmit FIFO. It pops one byte at a time through the FIFO's active-low read strobe and shifts it out on the serial line as a standard asynchronous frame: start bit, 8 data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. Bit timing comes from an internal baud counter.

---
 rtl/uart_tx_serializer_if.sv | 19 +
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// FIFO-side handshake of the transmit serializer: registered output byte,
// empty flag and the active-low one-cycle read strobe.
interface uart_tx_serializer_if;
    logic [7:0] fifo_data_i;
    logic       fifo_empty_i;
    logic       fifo_n_re_o;

    modport master (
        input  fifo_data_i,
        input  fifo_empty_i,
        output fifo_n_re_o
    );

    modport slave (
        output fifo_data_i,
        output fifo_empty_i,
        input  fifo_n_re_o
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Transmit serializer: pops bytes from the TX FIFO and shifts each out as an
// asynchronous frame (start, 8 data LSB first, optional parity, 1 or 2 stop).
module uart_tx_serializer #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    input  logic                        parity_en_i,
    input  logic                        parity_odd_i,
    input  logic                        stop2_i,
    uart_tx_serializer_if.master        fifo,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        frame_done_o
);

    localparam int DATA_W = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] STOP   = 3'd6;

    logic [2:0]        state, state_n;
    logic [15:0]       baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic              stop_cnt, stop_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bit, par_bit_n;
    logic              par_en_q, par_en_n;
    logic              stop2_q, stop2_n;
    logic              tx_q, tx_n;
    logic              baud_last;
    logic              frame_last;
    logic              start_ok;

    function automatic logic frame_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    assign baud_last  = (baud_cnt == CLKS_PER_BIT - 16'd1);
    assign frame_last = (state == STOP) && baud_last && (!stop2_q || stop_cnt);
    assign start_ok   = enable_i && !fifo.fifo_empty_i;

    always_comb begin
        state_n    = state;
        baud_cnt_n = 16'd0;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        case (state)
            IDLE: begin
                if (start_ok) state_n = FETCH;
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                shreg_n    = fifo.fifo_data_i;
                par_bit_n  = frame_parity(fifo.fifo_data_i, parity_odd_i);
                par_en_n   = parity_en_i;
                stop2_n    = stop2_i;
                bit_idx_n  = 3'd0;
                stop_cnt_n = 1'b0;
                state_n    = START;
            end
            START: begin
                if (baud_last) state_n = DATA;
                else           baud_cnt_n = baud_cnt + 16'd1;
            end
            DATA: begin
                if (baud_last) begin
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = par_en_q ? PARITY : STOP;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            PARITY: begin
                if (baud_last) state_n = STOP;
                else           baud_cnt_n = baud_cnt + 16'd1;
            end
            STOP: begin
                if (baud_last) begin
                    // second stop bit reuses the STOP state with a fresh bit period
                    if (stop2_q && !stop_cnt) stop_cnt_n = 1'b1;
                    else                      state_n = start_ok ? FETCH : IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // line level is registered from the next state so it changes with the state
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_bit_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            tx_q     <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg    <= shreg_n;
        par_bit  <= par_bit_n;
        par_en_q <= par_en_n;
        stop2_q  <= stop2_n;
    end

    assign fifo.fifo_n_re_o = (state != FETCH);
    assign busy_o           = (state != IDLE);
    assign frame_done_o     = frame_last;
    assign tx_o             = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model, serial-frame reference model and
// directed plus randomized scenarios.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       po;
        logic       s2;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;
    logic stop2 = 1'b0;
    logic tx, busy, done;

    uart_tx_serializer_if fif();

    uart_tx_serializer #(.CLKS_PER_BIT(16'd4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
        .fifo         (fif),
        .tx_o         (tx),
        .busy_o       (busy),
        .frame_done_o (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered head byte, empty flag lagging a read by one edge
    logic [7:0] fifo_q[$];
    frame_t     exp_q[$];
    bit         load_pending = 1'b0;

    initial begin
        bit emp_now;
        fif.fifo_data_i  = 8'h00;
        fif.fifo_empty_i = 1'b1;
        forever begin
            @(posedge clk);
            emp_now = (fifo_q.size() == 0);
            if (load_pending && !rst)
                exp_q.push_back('{d: fif.fifo_data_i, pe: parity_en, po: parity_odd, s2: stop2});
            load_pending = !fif.fifo_n_re_o && !rst;
            if (!fif.fifo_n_re_o && fifo_q.size() > 0)
                fif.fifo_data_i <= fifo_q.pop_front();
            fif.fifo_empty_i <= emp_now;
        end
    end

    // Serial-line reference: expected bit list per frame, compared every cycle
    int   cyc = 0, rd_cnt = 0, rd_in_rst = 0, frames_seen = 0;
    int   last_len = 0, end_cyc = 0;
    logic last_bit9 = 1'b0;
    int   gaps[$];

    initial begin
        frame_t f;
        logic   bitsq[$];
        int     pos, nlen;
        bit     in_frame;
        in_frame = 1'b0;
        pos = 0;
        nlen = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fif.fifo_n_re_o === 1'b0) rd_cnt++;
            if (rst) begin
                if (fif.fifo_n_re_o === 1'b0) rd_in_rst++;
                in_frame = 1'b0;
                exp_q.delete();
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        f = exp_q.pop_front();
                        bitsq.delete();
                        bitsq.push_back(1'b0);
                        for (int i = 0; i < 8; i++) bitsq.push_back(f.d[i]);
                        if (f.pe) bitsq.push_back(logic'(($countones(f.d) % 2 == 1) != f.po));
                        bitsq.push_back(1'b1);
                        if (f.s2) bitsq.push_back(1'b1);
                        nlen = bitsq.size() * CPB;
                        pos = 0;
                        in_frame = 1'b1;
                        gaps.push_back(cyc - end_cyc - 1);
                    end
                end
                if (in_frame) begin
                    chk("tx_bit", tx, bitsq[pos / CPB]);
                    chk("frame_done", done, (pos == nlen - 1));
                    if (done === 1'b1) last_len = pos + 1;
                    if (pos == 9 * CPB) last_bit9 = tx;
                    pos++;
                    if (pos == nlen) begin
                        in_frame = 1'b0;
                        frames_seen++;
                        end_cyc = cyc;
                    end
                end else begin
                    chk("done_idle", done, 1'b0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int budget = 3000;
        while (frames_seen < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 32'(frames_seen >= target), 32'd1);
    endtask

    task automatic wait_tx_fall(input string tag);
        int budget = 200;
        while (tx !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, tx, 1'b0);
    endtask

    task automatic idle_window(input string tag);
        int busy_cyc = 0, low_cyc = 0, rd0 = rd_cnt;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_cyc++;
            if (tx !== 1'b1) low_cyc++;
        end
        chk({tag, "_reads"}, rd_cnt - rd0, 0);
        chk({tag, "_busy"}, busy_cyc, 0);
        chk({tag, "_txlow"}, low_cyc, 0);
    endtask

    initial begin
        int rd0, fs0, g0, k, j;
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rd0, fs0, g0, k, j, budget;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_n_re", fif.fifo_n_re_o, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        tick();
        rst = 1'b0;

        // Idle with enable but empty FIFO, then non-empty FIFO but disabled
        enable = 1'b1;
        idle_window("idle_empty");
        tick();
        enable = 1'b0;
        fifo_q.push_back(8'hA5);
        idle_window("idle_disabled");

        // 0xA5, no parity, one stop bit; start latency from FETCH
        rd0 = rd_cnt;
        fs0 = frames_seen;
        tick();
        enable = 1'b1;
        k = 0;
        while (busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        j = 0;
        while (tx !== 1'b0 && j < 10) begin @(negedge clk); j++; end
        chk("start_latency", j, 2);
        wait_frames(fs0 + 1, "a5_frame");
        repeat (3) @(negedge clk);
        chk("a5_reads", rd_cnt - rd0, 1);
        chk("a5_len", last_len, 40);
        chk("a5_busy_after", busy, 1'b0);

        // Parity: even and odd on 0x07, then two stop bits
        tick();
        parity_en = 1'b1; parity_odd = 1'b0;
        fs0 = frames_seen;
        fifo_q.push_back(8'h07);
        wait_frames(fs0 + 1, "even_frame");
        chk("even_par_bit", last_bit9, 1'b1);
        chk("even_len", last_len, 44);
        tick();
        parity_odd = 1'b1;
        fifo_q.push_back(8'h07);
        wait_frames(fs0 + 2, "odd_frame");
        chk("odd_par_bit", last_bit9, 1'b0);
        tick();
        stop2 = 1'b1;
        fifo_q.push_back(8'h07);
        wait_frames(fs0 + 3, "stop2_frame");
        chk("stop2_len", last_len, 48);

        // Three queued bytes back to back
        tick();
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        rd0 = rd_cnt;
        fs0 = frames_seen;
        g0 = gaps.size();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        wait_frames(fs0 + 3, "burst_frames");
        repeat (5) @(negedge clk);
        chk("burst_reads", rd_cnt - rd0, 3);
        chk("burst_gap1", gaps[g0 + 1], 2);
        chk("burst_gap2", gaps[g0 + 2], 2);

        // Config changes mid-frame only affect the following frame
        tick();
        fs0 = frames_seen;
        fifo_q.push_back(8'h3C);
        wait_tx_fall("cfg_start");
        tick();
        parity_en = 1'b1; stop2 = 1'b1;
        wait_frames(fs0 + 1, "cfg_frame1");
        chk("cfg_len1", last_len, 40);
        tick();
        fifo_q.push_back(8'hC3);
        wait_frames(fs0 + 2, "cfg_frame2");
        chk("cfg_len2", last_len, 48);

        // Enable dropped mid-frame: frame completes, no further read
        tick();
        parity_en = 1'b0; stop2 = 1'b0;
        rd0 = rd_cnt;
        fs0 = frames_seen;
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h42);
        wait_tx_fall("drop_start");
        tick();
        enable = 1'b0;
        wait_frames(fs0 + 1, "drop_frame");
        repeat (60) @(negedge clk);
        chk("drop_reads", rd_cnt - rd0, 1);
        chk("drop_busy", busy, 1'b0);

        // Reset during DATA bit 3; next byte then goes out cleanly
        rd0 = rd_cnt;
        fs0 = frames_seen;
        tick();
        fifo_q.push_back(8'h9E);
        enable = 1'b1;
        wait_tx_fall("rst_start");
        repeat (17) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        wait_frames(fs0 + 1, "rst_next_frame");
        repeat (5) @(negedge clk);
        chk("rst_reads", rd_cnt - rd0, 2);
        chk("rst_no_read", rd_in_rst, 0);

        // Randomized bytes with configuration toggling at random times
        rd0 = rd_cnt;
        fs0 = frames_seen;
        tick();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'($urandom));
        budget = 4000;
        while (frames_seen < fs0 + 8 && budget > 0) begin
            tick();
            budget--;
            if ($urandom_range(0, 7) == 0) {parity_en, parity_odd, stop2} = 3'($urandom);
        end
        chk("rand_frames", 32'(frames_seen >= fs0 + 8), 32'd1);
        repeat (10) @(negedge clk);
        chk("rand_reads", rd_cnt - rd0, 8);
        chk("rand_exp_left", exp_q.size(), 0);
        chk("rand_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
